data_mem_responder: RTL

- Multi-cycle data-memory target that answers CPU load/store requests over a valid/ready request channel and a valid/ready response channel.
- It replaces the CPU's zero-latency data memory path with a handshaked one, so the datapath can later run against slow memory.
- It holds a word-addressed RAM, services one transaction at a time and flags illegal accesses.

---
 rtl/data_mem_responder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Handshaked data-memory target for CPU load/store traffic. Holds a
//   word-addressed RAM of DEPTH 32-bit words and services one transaction
//   at a time. Each accepted request takes LATENCY edges to produce a
//   response. Misaligned or out-of-range accesses are flagged, and an
//   erroneous store leaves memory unchanged.
//
//   State   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | ready for a request; captures we/addr/wdata on req handshake
//   S_WAIT  | latency countdown; request inputs ignored
//   S_RESP  | response held on rsp_* until rsp_ready_i
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   req_valid_i  request present
//   req_ready_o  responder can accept a request (registered)
//   req_we_i     1 = store word, 0 = load word
//   req_addr_i   byte address
//   req_wdata_i  store data
//   rsp_valid_o  response present (registered)
//   rsp_ready_i  requester consumes the response
//   rsp_rdata_o  load data; 0 for stores and errors
//   rsp_err_o    access was misaligned or out of range
//
// DEPTH must be at least 2. LATENCY must be in 1..15.

module data_mem_responder #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        access_err;
    logic [AW-1:0] mem_idx;
    logic [31:0] mem_rd;
    logic        commit;
    logic        mem_we;

    // With LATENCY=1 the commit happens on the acceptance edge itself, so
    // the access must be evaluated straight from the request inputs; in
    // every other case it comes from the captured registers.
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_we    = req_we_i;
            cur_addr  = req_addr_i;
            cur_wdata = req_wdata_i;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    // Full 30-bit word-address compare: no aliasing of high addresses.
    assign access_err = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= 30'(DEPTH));
    assign mem_idx    = cur_addr[AW+1:2];
    assign mem_rd     = mem_q[mem_idx];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        commit      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit) begin
            rsp_valid_d = 1'b1;
            err_d       = access_err;
            rdata_d     = (!access_err && !cur_we) ? mem_rd : 32'h0;
        end

        mem_we = commit && !access_err && cur_we;

        // Ready is decoded from the next state and registered, so it never
        // depends combinationally on req_valid_i.
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_idx] <= cur_wdata;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule
